// File: rtl/memlcd_pkg.sv
// Shared definitions for the memory-LCD serial receiver.
//   state_t          : receiver frame-parsing states
//   M0/M1/M2_BIT     : bit positions inside the 8-bit mode field
//   *_BITS           : serial field widths
//   MIN_SCLK_PERIOD  : minimum SCLK period in wb_clk_i cycles that the
//                      synchroniser path can follow reliably
package memlcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MODE,
    ADDR,
    DATA,
    TRAIL
  } state_t;

  localparam int M0_BIT = 0;  // write command
  localparam int M1_BIT = 1;  // VCOM level
  localparam int M2_BIT = 2;  // all-clear command

  localparam int MODE_BITS  = 8;
  localparam int ADDR_BITS  = 8;
  localparam int TRAIL_BITS = 8;
  localparam int WORD_BITS  = 32;

  localparam int MIN_SCLK_PERIOD = 8;

endpackage

// File: rtl/memlcd_sync.sv
// Two-flop synchroniser with edge detection for one asynchronous pin.
//   clk  : sampling clock
//   rst  : synchronous active-high reset
//   d    : asynchronous input pin
//   q    : synchronised level
//   rise : one-cycle pulse on a synchronised 0->1 transition
//   fall : one-cycle pulse on a synchronised 1->0 transition
module memlcd_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop in
  // the chain samples the pre-edge value of its predecessor.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/memlcd_rx.sv
// Memory-LCD serial receiver: decodes the SCS/SCLK/SI write protocol into
// 32-bit pixel words on a valid/ready stream.
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   lcd_scs, lcd_sclk, lcd_si : asynchronous serial pins
//   m_valid/m_ready/m_data    : pixel word stream
//   m_line, m_word            : gate-line address and word index of m_data
//   vcom_o                    : last received M1 bit
//   clear_o, frame_done       : one-cycle event pulses
//   err_overflow, err_framing : sticky error flags, cleared by err_clr
//   lines_rcvd                : completed-line counter
// Build option: MEMLCD_RX_LINECNT_EN compiles in the line counter;
// without it lines_rcvd reads 0.
module memlcd_rx
  import memlcd_pkg::*;
#(
  parameter int LINE_BITS = 128
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        lcd_scs,
  input  logic        lcd_sclk,
  input  logic        lcd_si,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [7:0]  m_line,
  output logic [3:0]  m_word,
  output logic        vcom_o,
  output logic        clear_o,
  output logic        frame_done,
  output logic        err_overflow,
  output logic        err_framing,
  input  logic        err_clr,
  output logic [15:0] lines_rcvd
);

  localparam int CNT_W = $clog2(LINE_BITS) + 1;
  localparam int WSH   = $clog2(WORD_BITS);

  logic scs_q, scs_rise, scs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic si_q, si_rise, si_fall;

  memlcd_sync u_sync_scs (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(lcd_scs),
    .q(scs_q), .rise(scs_rise), .fall(scs_fall)
  );
  memlcd_sync u_sync_sclk (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(lcd_sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  memlcd_sync u_sync_si (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(lcd_si),
    .q(si_q), .rise(si_rise), .fall(si_fall)
  );

  state_t                 state, state_next;
  logic [CNT_W-1:0]       bit_cnt;
  logic [MODE_BITS-2:0]   mode_sr;
  logic [ADDR_BITS-2:0]   addr_sr;
  logic [WORD_BITS-2:0]   word_sr;
  logic [7:0]             cur_line;
  logic                   line_seen;
  logic [1:0]             settle;
  logic                   armed;

  // Shift registers hold all but the newest bit, so the full field is the
  // live SI bit on top of the register (LSB-first reception).
  logic [MODE_BITS-1:0]   mode_full;
  logic [ADDR_BITS-1:0]   addr_full;
  logic [WORD_BITS-1:0]   word_full;
  logic [3:0]             word_idx;

  logic sample, fall_evt, fall_legal;
  logic mode_done, addr_done, word_done, line_done;

  assign mode_full = {si_q, mode_sr};
  assign addr_full = {si_q, addr_sr};
  assign word_full = {si_q, word_sr};
  assign word_idx  = 4'(bit_cnt >> WSH);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    fall_evt   = 1'b0;
    fall_legal = 1'b0;
    mode_done  = 1'b0;
    addr_done  = 1'b0;
    word_done  = 1'b0;
    line_done  = 1'b0;

    if (state != IDLE && scs_fall) begin
      // "ADDR with 8 bits collected" is DATA before its first bit.
      fall_evt   = 1'b1;
      fall_legal = (state == ADDR || state == DATA) && (bit_cnt == '0);
      state_next = IDLE;
    end else begin
      sample = sclk_rise && (state != IDLE);
      unique case (state)
        IDLE: if (scs_rise && armed) state_next = MODE;
        MODE: if (sclk_rise && bit_cnt == CNT_W'(MODE_BITS - 1)) begin
          mode_done  = 1'b1;
          state_next = mode_full[M0_BIT] ? ADDR : TRAIL;
        end
        ADDR: if (sclk_rise && bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
          addr_done  = 1'b1;
          state_next = DATA;
        end
        DATA: if (sclk_rise) begin
          word_done = (bit_cnt[WSH-1:0] == '1);
          if (bit_cnt == CNT_W'(LINE_BITS - 1)) begin
            line_done  = 1'b1;
            state_next = TRAIL;
          end
        end
        TRAIL: if (sclk_rise && bit_cnt == CNT_W'(TRAIL_BITS - 1)) state_next = ADDR;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt      <= '0;
      mode_sr      <= '0;
      addr_sr      <= '0;
      word_sr      <= '0;
      cur_line     <= '0;
      line_seen    <= 1'b0;
      settle       <= '0;
      armed        <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_line       <= '0;
      m_word       <= '0;
      vcom_o       <= 1'b0;
      clear_o      <= 1'b0;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
      err_framing  <= 1'b0;
    end else begin
      clear_o    <= 1'b0;
      frame_done <= 1'b0;

      // After reset the synchroniser needs two cycles to show the real pin;
      // an SCS already high at release must not look like a frame start.
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle[1] && !scs_q) armed <= 1'b1;

      if (state_next != state) bit_cnt <= '0;
      else if (sample)         bit_cnt <= bit_cnt + CNT_W'(1);

      if (sample) begin
        if (state == MODE) mode_sr <= mode_full[MODE_BITS-1:1];
        if (state == ADDR) addr_sr <= addr_full[ADDR_BITS-1:1];
        if (state == DATA) word_sr <= word_full[WORD_BITS-1:1];
      end

      if (state == IDLE && state_next == MODE) line_seen <= 1'b0;
      if (line_done) line_seen <= 1'b1;

      if (mode_done) begin
        vcom_o <= mode_full[M1_BIT];
        if (!mode_full[M0_BIT] && mode_full[M2_BIT]) clear_o <= 1'b1;
      end

      if (addr_done) cur_line <= addr_full;

      // The new address shows on m_line at the first data bit unless a
      // held word still owns the output registers.
      if (sample && state == DATA && bit_cnt == '0 && !m_valid) m_line <= cur_line;

      if (word_done) begin
        if (m_valid && !m_ready) begin
          err_overflow <= 1'b1;
        end else begin
          m_valid <= 1'b1;
          m_data  <= word_full;
          m_line  <= cur_line;
          m_word  <= word_idx;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      if (word_done && m_valid && !m_ready) err_overflow <= 1'b1;
      else if (err_clr)                     err_overflow <= 1'b0;

      if (fall_evt && !fall_legal) err_framing <= 1'b1;
      else if (err_clr)            err_framing <= 1'b0;

      if (fall_evt && fall_legal && line_seen) frame_done <= 1'b1;
    end
  end

`ifdef MEMLCD_RX_LINECNT_EN
  logic [15:0] line_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)       line_cnt <= '0;
    else if (line_done) line_cnt <= line_cnt + 16'd1;
  end

  assign lines_rcvd = line_cnt;
`else
  assign lines_rcvd = 16'd0;
`endif

  logic unused_sig;
  assign unused_sig = ^{sclk_q, sclk_fall, si_rise, si_fall,
                        mode_full[MODE_BITS-1:M2_BIT+1]};

endmodule

// File: tb/tb_memlcd_rx.sv
// Self-checking bench for memlcd_rx: drives serial frames on the LCD pins,
// pushes expected pixel words into a scoreboard queue and compares them as
// the stream is accepted.
module tb_memlcd_rx;
  import memlcd_pkg::*;

  localparam int HALF  = MIN_SCLK_PERIOD / 2 + 1;
  localparam int WORDS = 128 / WORD_BITS;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i, lcd_scs, lcd_sclk, lcd_si, m_ready, err_clr;
  logic        m_valid, vcom_o, clear_o, frame_done, err_overflow, err_framing;
  logic [31:0] m_data;
  logic [7:0]  m_line;
  logic [3:0]  m_word;
  logic [15:0] lines_rcvd;

  memlcd_rx dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .lcd_scs(lcd_scs), .lcd_sclk(lcd_sclk), .lcd_si(lcd_si),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_line(m_line), .m_word(m_word), .vcom_o(vcom_o),
    .clear_o(clear_o), .frame_done(frame_done),
    .err_overflow(err_overflow), .err_framing(err_framing),
    .err_clr(err_clr), .lines_rcvd(lines_rcvd)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [7:0]  line;
    logic [3:0]  word;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_clr    = 0;
  int   n_fd     = 0;
  int   n_words  = 0;
  int   exp_lines = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sample away from the rising edge, count pulses, score words.
  always @(negedge wb_clk_i) begin
    exp_t e;
    if (clear_o)    n_clr++;
    if (frame_done) n_fd++;
    if (!wb_rst_i && m_valid && m_ready) begin
      n_words++;
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("word_data", m_data, e.data);
        check("word_line", 32'(m_line), 32'(e.line));
        check("word_index", 32'(m_word), 32'(e.word));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      lcd_sclk = 1'b0;
      lcd_si   = val[i];
      tick(HALF);
      lcd_sclk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic send_word(input logic [7:0] line, input logic [3:0] idx, input logic [31:0] data);
    exp_t e;
    e.line = line;
    e.word = idx;
    e.data = data;
    exp_q.push_back(e);
    send_bits(data, 32);
  endtask

  task automatic send_line(input logic [7:0] addr, input bit rand_data);
    logic [31:0] d;
    send_bits(32'(addr), 8);
    for (int w = 0; w < WORDS; w++) begin
      d = rand_data ? $urandom : 32'hA5A5_A5A5;
      send_word(addr, 4'(w), d);
    end
    send_bits(32'h0, 8);
`ifdef MEMLCD_RX_LINECNT_EN
    exp_lines++;
`endif
  endtask

  task automatic frame_start(input logic [7:0] mode);
    lcd_sclk = 1'b0;
    lcd_scs  = 1'b1;
    tick(6);
    send_bits(32'(mode), 8);
  endtask

  task automatic frame_end();
    lcd_sclk = 1'b0;
    tick(HALF);
    lcd_scs = 1'b0;
    tick(8);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check($sformatf("%s_m_valid", pfx), 32'(m_valid), 32'd0);
    check($sformatf("%s_m_data", pfx), m_data, 32'd0);
    check($sformatf("%s_m_line", pfx), 32'(m_line), 32'd0);
    check($sformatf("%s_m_word", pfx), 32'(m_word), 32'd0);
    check($sformatf("%s_vcom", pfx), 32'(vcom_o), 32'd0);
    check($sformatf("%s_clear", pfx), 32'(clear_o), 32'd0);
    check($sformatf("%s_frame_done", pfx), 32'(frame_done), 32'd0);
    check($sformatf("%s_err_ovf", pfx), 32'(err_overflow), 32'd0);
    check($sformatf("%s_err_frm", pfx), 32'(err_framing), 32'd0);
    check($sformatf("%s_lines", pfx), 32'(lines_rcvd), 32'd0);
  endtask

  initial begin
    int fd0, clr0, w0;
    logic [31:0] held;

    wb_rst_i = 1'b1;
    lcd_scs  = 1'b0;
    lcd_sclk = 1'b0;
    lcd_si   = 1'b0;
    m_ready  = 1'b1;
    err_clr  = 1'b0;
    tick(3);
    check_all_zero("reset");
    wb_rst_i = 1'b0;
    tick(5);

    // Single-line write, all words 0xA5A5A5A5, then 8 dummy address bits.
    fd0 = n_fd; w0 = n_words;
    frame_start(8'h01);
    send_line(8'h05, 1'b0);
    send_bits(32'hFF, 8);
    frame_end();
    check("t1_words", 32'(n_words - w0), 32'd4);
    check("t1_frame_done", 32'(n_fd - fd0), 32'd1);
    check("t1_lines", 32'(lines_rcvd), 32'(exp_lines));
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Clear command: M1=1, M2=1, M0=0.
    fd0 = n_fd; w0 = n_words; clr0 = n_clr;
    frame_start(8'h06);
    send_bits(32'h0, 8);
    frame_end();
    check("t2_vcom", 32'(vcom_o), 32'd1);
    check("t2_clear_pulses", 32'(n_clr - clr0), 32'd1);
    check("t2_no_words", 32'(n_words - w0), 32'd0);
    check("t2_no_frame_done", 32'(n_fd - fd0), 32'd0);
    check("t2_m_valid", 32'(m_valid), 32'd0);

    // Backpressure: second word completes while the first is held.
    fd0 = n_fd;
    m_ready = 1'b0;
    held = 32'h1357_9BDF;
    frame_start(8'h01);
    check("t3_vcom_cleared", 32'(vcom_o), 32'd0);
    send_bits(32'h20, 8);
    send_word(8'h20, 4'd0, held);
    check("t3_valid_first", 32'(m_valid), 32'd1);
    check("t3_no_ovf_yet", 32'(err_overflow), 32'd0);
    send_bits(32'hDEAD_BEEF, 32);
    check("t3_ovf_set", 32'(err_overflow), 32'd1);
    check("t3_held_data", m_data, held);
    check("t3_held_word", 32'(m_word), 32'd0);
    check("t3_held_line", 32'(m_line), 32'h20);
    pulse_err_clr();
    check("t3_ovf_cleared", 32'(err_overflow), 32'd0);
    m_ready = 1'b1;
    tick(3);
    send_word(8'h20, 4'd2, 32'h0F0F_0F0F);
    send_word(8'h20, 4'd3, 32'h8000_0001);
    send_bits(32'h0, 8);
`ifdef MEMLCD_RX_LINECNT_EN
    exp_lines++;
`endif
    frame_end();
    check("t3_frame_done", 32'(n_fd - fd0), 32'd1);
    check("t3_lines", 32'(lines_rcvd), 32'(exp_lines));
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Framing error: SCS falls after 40 data bits.
    fd0 = n_fd;
    frame_start(8'h01);
    send_bits(32'h30, 8);
    send_word(8'h30, 4'd0, 32'hC0FF_EE11);
    send_bits(32'h5A, 8);
    frame_end();
    check("t4_err_framing", 32'(err_framing), 32'd1);
    check("t4_no_frame_done", 32'(n_fd - fd0), 32'd0);
    check("t4_lines_unchanged", 32'(lines_rcvd), 32'(exp_lines));
    check("t4_m_valid", 32'(m_valid), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Multi-line write; err_framing must still be sticky.
    fd0 = n_fd; w0 = n_words;
    frame_start(8'h03);
    send_line(8'h10, 1'b1);
    send_line(8'h11, 1'b1);
    send_line(8'h7F, 1'b1);
    frame_end();
    check("t5_words", 32'(n_words - w0), 32'd12);
    check("t5_frame_done", 32'(n_fd - fd0), 32'd1);
    check("t5_lines", 32'(lines_rcvd), 32'(exp_lines));
    check("t5_vcom", 32'(vcom_o), 32'd1);
    check("t5_err_framing_sticky", 32'(err_framing), 32'd1);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-DATA with a word held on the output.
    m_ready = 1'b0;
    frame_start(8'h03);
    send_bits(32'h40, 8);
    send_bits(32'h1234_5678, 32);
    check("t6_held_before_reset", 32'(m_valid), 32'd1);
    send_bits(32'hFFFF_FFFF, 20);
    wb_rst_i = 1'b1;
    tick(1);
    check_all_zero("t6_rst");
    lcd_scs  = 1'b0;
    lcd_sclk = 1'b0;
    tick(3);
    wb_rst_i = 1'b0;
    m_ready  = 1'b1;
    tick(6);
    exp_lines = 0;
    check("t6_no_framing_after_reset", 32'(err_framing), 32'd0);
    fd0 = n_fd; w0 = n_words;
    frame_start(8'h01);
    send_line(8'h22, 1'b1);
    frame_end();
    check("t6_words", 32'(n_words - w0), 32'd4);
    check("t6_frame_done", 32'(n_fd - fd0), 32'd1);
    check("t6_lines", 32'(lines_rcvd), 32'(exp_lines));
    check("t6_err_framing", 32'(err_framing), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memlcd_rx.md
MEMLCD_RX -- requirements
Module: memlcd_rx

Interface
REQ-001 SHALL have parameter LINE_BITS, default 128, pixel bits per line; legal values are multiples of 32 in the range 32..512.
REQ-002 SHALL have port wb_clk_i, input, 1 bit, the single clock.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port lcd_scs, input, 1 bit, chip select, active-high, asynchronous to wb_clk_i.
REQ-005 SHALL have port lcd_sclk, input, 1 bit, serial clock, asynchronous.
REQ-006 SHALL have port lcd_si, input, 1 bit, serial data, asynchronous.
REQ-007 SHALL have port m_valid, output, 1 bit, pixel word available.
REQ-008 SHALL have port m_ready, input, 1 bit, consumer accepts the word.
REQ-009 SHALL have port m_data, output, 32 bits, pixel word.
REQ-010 SHALL have port m_line, output, 8 bits, gate-line address of the word.
REQ-011 SHALL have port m_word, output, 4 bits, word index within the line.
REQ-012 SHALL have port vcom_o, output, 1 bit, last received M1 bit.
REQ-013 SHALL have port clear_o, output, 1 bit, one-cycle all-clear pulse.
REQ-014 SHALL have port frame_done, output, 1 bit, one-cycle pulse at the end of a write frame.
REQ-015 SHALL have ports err_overflow and err_framing, outputs, 1 bit each, sticky error flags.
REQ-016 SHALL have port err_clr, input, 1 bit, clears both error flags.
REQ-017 SHALL have port lines_rcvd, output, 16 bits, count of completed lines.

Function
REQ-018 SHALL pass lcd_scs, lcd_sclk and lcd_si through 2-flop synchronisers; lcd_si is sampled on the detected SCLK rising edge, 3 wb_clk_i cycles after the pin edge; the SCLK period must be at least 8 wb_clk_i cycles.
REQ-019 SHALL receive all fields LSB-first; the first data bit of a word lands in m_data[0].
REQ-020 SHALL implement states IDLE, MODE, ADDR, DATA and TRAIL with these transitions.
- IDLE to MODE: on an SCS rise.
- MODE: 8 bits; bit0=M0 (write), bit1=M1 (VCOM), bit2=M2 (clear).
REQ-021 SHALL leave MODE as follows after its 8th bit.
- Update vcom_o from M1.
- M0=1: go to ADDR.
- M0=0 and M2=1: pulse clear_o, then go to TRAIL.
- Otherwise: go to TRAIL.
REQ-022 SHALL collect 8 bits in ADDR and then go to DATA; the captured address is applied to m_line only when the first DATA bit arrives.
REQ-023 SHALL collect LINE_BITS bits in DATA, emitting one word every 32 bits with m_word running 0..LINE_BITS/32-1.
REQ-024 SHALL, after the last data bit, increment lines_rcvd (wrapping 65535 to 0), then collect 8 bits in TRAIL and return to ADDR.
REQ-025 SHALL assert m_valid the cycle after the 32nd bit's sample event, holding m_data, m_line and m_word stable until m_valid&&m_ready.
REQ-026 SHALL, if a word completes while m_valid=1 and m_ready=0, drop the new word, keep the held word and set err_overflow.
- Completion coinciding with acceptance is not an overflow; the new word loads.
REQ-027 SHALL go to IDLE on an SCS fall in any state.
- Legal fall: in ADDR with 0 or 8 bits collected, or in TRAIL after its 8th bit.
- Any other fall sets err_framing.
- Any fall discards a partial word.
REQ-028 SHALL pulse frame_done on a legal SCS fall when at least one line completed since the SCS rise.
REQ-029 SHALL give err_clr effect one cycle after assertion; a simultaneous error event takes priority over err_clr.
REQ-030 SHALL ignore SCLK edges in IDLE.

Reset
REQ-031 SHALL, while wb_rst_i=1 on a wb_clk_i edge, set the state to IDLE, clear all counters, synchronisers and sticky flags, and drive every output to 0 (m_valid, m_data, m_line, m_word, vcom_o, clear_o, frame_done, both err flags, lines_rcvd).
REQ-032 SHALL treat reset mid-frame as abandoning the frame; after reset the block waits for the next SCS rise, with no framing error reported.

Configuration
REQ-033 SHALL compile the line counter in only when macro MEMLCD_RX_LINECNT_EN is defined.
- Defined: lines_rcvd behaves per REQ-024.
- Undefined: lines_rcvd is tied to 0 and the counter is not synthesised.
- The port exists in both cases.

Structure
REQ-034 SHALL place the state enum, MODE bit positions (M0=0, M1=1, M2=2), field widths (MODE_BITS=8, ADDR_BITS=8, TRAIL_BITS=8, WORD_BITS=32) and the minimum SCLK period constant in shared package memlcd_pkg.
REQ-035 SHALL use a sub-module memlcd_sync (2-flop synchroniser plus rise/fall detect), instantiated three times.

Verification
REQ-036 SHALL cover a single-line write: mode 0x01, addr 0x05, 128 bits of 0xA5A5A5A5 words, trailer, 8 dummy bits, SCS fall -> 4 words with m_line=5, m_word=0..3, data 0xA5A5A5A5; one frame_done pulse; lines_rcvd=1.
REQ-037 SHALL cover a clear command: mode 0x06 plus 8 trailer bits -> vcom_o=1 and one clear_o pulse; no m_valid, no frame_done.
REQ-038 SHALL cover backpressure: m_ready=0 across two word completions -> first word held, err_overflow=1; err_clr pulse -> err_overflow=0 the next cycle.
REQ-039 SHALL cover a framing error: SCS fall after 40 DATA bits -> err_framing=1, state IDLE, no frame_done, lines_rcvd unchanged.
REQ-040 SHALL cover a multi-line write: three lines at addr 0x10, 0x11, 0x7F -> 12 words in order with the correct m_line; lines_rcvd=3, or 0 with MEMLCD_RX_LINECNT_EN undefined.
REQ-041 SHALL cover reset mid-DATA: assert wb_rst_i, then send a fresh frame -> all outputs 0 during reset and the fresh frame is received correctly.
